// File: rtl/serial_rx_if.sv
// Serial receiver bus: raw serial line in, parallel word and strobes out.
// master = line driver / word consumer side, slave = receiver.
interface serial_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx, input data, valid, frame_err, busy);
  modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/serial_rx.sv
// Bit-serial frame receiver: start bit, DATA_BITS data bits LSB first,
// optional even parity bit, stop bit. Emits a one-cycle valid strobe per
// good word or a one-cycle frame_err strobe per bad frame.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds an even-parity bit).
module serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic        clk,
  input logic        rst,
  serial_rx_if.slave bus
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HI
  } state_t;

  state_t               state;
  logic [1:0]           sync;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] sreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic                 rxs;
  logic                 stop_ok;

  assign rxs = sync[1];

`ifdef SERIAL_RX_PARITY_EN
  logic par_err;
  assign stop_ok = rxs & ~par_err;
`else
  assign stop_ok = rxs;
`endif

  // Synchronizer, frame FSM, bit timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync        <= 2'b11;
      timer       <= '0;
      idx         <= '0;
      sreg        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      sync        <= {sync[0], bus.rx};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            timer  <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          // Mid start bit: a line already back high was a glitch.
          if (timer == HALF_M1) begin
            timer <= '0;
            if (!rxs) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == BIT_LAST) begin
            timer     <= '0;
            sreg[idx] <= rxs;
            if (idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          // Even parity: data bits XOR parity bit must be 0.
          if (timer == BIT_LAST) begin
            timer   <= '0;
            par_err <= (^sreg) ^ rxs;
            state   <= STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        STOP: begin
          if (timer == BIT_LAST) begin
            timer <= '0;
            if (stop_ok) begin
              data_q  <= sreg;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_HI;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_HI: begin
          // Hold off until the line returns high so a break cannot retrigger.
          if (rxs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/serial_rx.md
# serial_rx

Serial frame receiver for the lab-exam datapath: the receiving end of the single-wire, bit-serial link driven by the team's shift-register transmitter. It samples an idle-high serial line, detects a start bit, and assembles LSB-first data bits into a parallel word. It flags each word with a one-cycle valid strobe, or with an error strobe for a bad frame. It sits between the external serial pin and any register file or display logic that consumes bytes.

## Interface
Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, ≥ 4.
- DATA_BITS, 8, data bits per frame; 1–16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- rx  input  1  serial line; idle = 1; asynchronous to frame timing.
- data  output  DATA_BITS  last good word received; reset 0.
- valid  output  1  one-cycle strobe, data just updated; reset 0.
- frame_err  output  1  one-cycle strobe, stop bit (or parity) bad; reset 0.
- busy  output  1  high in any state except IDLE; reset 0.

## Operation
- rx passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value, rxs.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit (see Configuration), stop bit (1).
- FSM states: IDLE, START, DATA, PARITY (only if enabled), STOP, WAIT_HI.
- IDLE: when rxs = 0, go to START and clear the bit-timer.
- START: at timer = CLKS_PER_BIT/2 − 1 (mid start bit), check rxs.
  - rxs = 0: go to DATA, clear the timer and bit index.
  - rxs = 1: glitch; return to IDLE with no strobe.
- DATA: every CLKS_PER_BIT cycles, shift rxs into the shift register at the current bit index. After bit DATA_BITS−1, go to PARITY or STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rxs = 1 and no parity error: load data from the shift register, pulse valid, go to IDLE.
  - Otherwise: pulse frame_err, leave data unchanged, go to WAIT_HI.
- WAIT_HI: stay until rxs = 1, then go to IDLE. This stops a held-low line (break) from retriggering frames.
- valid and frame_err are mutually exclusive and never high for more than one cycle.
- rst in any state: FSM goes to IDLE; the timer, index, shift register and outputs clear; the synchronizer is set to 1. A partially received frame is discarded silently.

## Timing
- Let T0 be the clock edge at which the raw rx is first sampled low (into sync stage 1).
- rxs goes low 2 edges after T0.
- The mid-start check happens CLKS_PER_BIT/2 edges after that.
- The last sample (stop bit) happens (DATA_BITS + 1 [+1 with parity]) × CLKS_PER_BIT edges after the mid-start check.
- valid / frame_err are registered and high for the cycle after the stop sample edge.
- With defaults and no parity: strobe high in cycle 2 + 2 + 36 = 40 after T0. With parity: 44.
- Back-to-back frames: a start bit beginning immediately after the stop bit is accepted. IDLE re-arms in the cycle following the strobe, which is within the second half of the stop bit.
- busy rises 1 cycle after rxs goes low and falls in the cycle the strobe is asserted.

## Configuration
- Macro: SERIAL_RX_PARITY_EN.
- Defined: the PARITY state samples one even-parity bit after the data bits. The XOR of the data bits and the parity bit must be 0. On mismatch, still sample the stop bit, then assert frame_err and enter WAIT_HI; data is not updated.
- Undefined: no PARITY state; the stop bit directly follows the data bits; frame_err reflects the stop bit only.

## Test plan
- Reset, then frame 0xA5 at 4 clocks/bit: data = 0xA5, valid = 1 for exactly one cycle at cycle 40 after the start edge, and frame_err stays 0.
- rx low for 1 cycle only (glitch): no valid, no frame_err. busy returns to 0 by mid-start check + 1, and the next good frame 0x3C is received correctly.
- Frame 0x5A with stop bit = 0, then rx held low for 20 cycles, then high: frame_err pulses once, data keeps its prior value, no new frame starts until rx returns high, and a following 0x81 gives valid.
- Back-to-back frames 0x00 then 0xFF with no idle gap: two valid pulses, 40 cycles apart, with data 0x00 then 0xFF.
- rst asserted for 1 cycle in the middle of data bit 3: outputs go to 0 and busy = 0 on the next cycle. No strobe appears for that frame, and the next frame 0x12 is received.
- With SERIAL_RX_PARITY_EN: 0x07 with parity 1 gives valid at cycle 44. 0x07 with parity 0 gives frame_err at cycle 44 and leaves data unchanged.
